// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Sequencer state: free running, or waiting on a data-memory access.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  // Register $0 is hard-wired to zero and never carries a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default number of MEM_WAIT cycles without ack before the error flag sets.
  localparam int DEF_MEM_TIMEOUT = 64;

  // Default width of the stall-cycle counter.
  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction currently in ID needs a one-cycle bubble.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  logic dest_valid;
  logic src_match;

  // Hazard exists only for a real (non-$0) destination matching either source.
  always_comb begin
    dest_valid = (ex_rt != REG_ZERO);
    src_match  = (ex_rt == id_rs) || (ex_rt == id_rt);
    load_use   = mem_read && dest_valid && src_match;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
// Handshake: mem_req_o is high for every cycle a load/store sits in MEM.
// The access completes in the cycle mem_ack_i is high while mem_req_o is
// high; the pipeline advances in that same cycle. Any cycle with mem_req_o
// high and mem_ack_i low freezes the whole pipeline. An ack coincident with
// the first request cycle means a zero-wait access and no stall at all.
//
// Stall priority (highest first): memory wait, load-use bubble, branch flush.
// A taken branch that coincides with a memory wait is simply not flushed in
// that cycle; it stays in ID and is flushed on the first advancing cycle.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_Rt_i,
  input  logic [4:0]       IF_ID_Rs_i,
  input  logic [4:0]       IF_ID_Rt_i,
  input  logic             Branch_taken_i,
  input  logic             EX_MEM_MemRead_i,
  input  logic             EX_MEM_MemWrite_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IF_IDWrite_o,
  output logic             ID_EX_Bubble_o,
  output logic             IF_ID_Flush_o,
  output logic             Pipe_Stall_o,
  output logic             mem_req_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             dbg_state
);

  localparam int                TCNT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX    = '1;
  localparam logic [TCNT_W-1:0] TIMEOUT_VAL = TCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] tcnt_next;
  logic              memop;
  logic              mem_stall;
  logic              load_use;
  logic              err_set;

  load_use_detect u_load_use_detect (
    .mem_read (ID_EX_MemRead_i),
    .ex_rt    (ID_EX_Rt_i),
    .id_rs    (IF_ID_Rs_i),
    .id_rt    (IF_ID_Rt_i),
    .load_use (load_use)
  );

  // A memory op stalls whenever it is outstanding and not acknowledged.
  always_comb begin
    memop     = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;
    mem_stall = memop & ~mem_ack_i;
  end

  // State, timeout counter and sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      tcnt      <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      if (err_set) begin
        mem_err_o <= 1'b1;
      end
    end
  end

  // Next state and timeout count; the access is never aborted on timeout.
  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next = MEM_WAIT;
          tcnt_next  = TCNT_W'(1);
        end else begin
          tcnt_next = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i || !memop) begin
          // Completed, or the request vanished without an ack.
          state_next = RUN;
          tcnt_next  = '0;
        end else if (tcnt != TCNT_MAX) begin
          tcnt_next = tcnt + TCNT_W'(1);
        end
      end
      default: begin
        state_next = RUN;
        tcnt_next  = '0;
      end
    endcase
    err_set = mem_stall && (tcnt_next >= TIMEOUT_VAL);
  end

  // Pipeline controls, prioritised; idle values while reset is held.
  always_comb begin
    PCWrite_o      = 1'b1;
    IF_IDWrite_o   = 1'b1;
    ID_EX_Bubble_o = 1'b0;
    IF_ID_Flush_o  = 1'b0;
    Pipe_Stall_o   = 1'b0;
    mem_req_o      = 1'b0;
    if (!rst_i) begin
      mem_req_o = memop;
      if (mem_stall) begin
        Pipe_Stall_o = 1'b1;
        PCWrite_o    = 1'b0;
        IF_IDWrite_o = 1'b0;
      end else if (load_use) begin
        PCWrite_o      = 1'b0;
        IF_IDWrite_o   = 1'b0;
        ID_EX_Bubble_o = 1'b1;
      end else if (Branch_taken_i) begin
        IF_ID_Flush_o = 1'b1;
      end
    end
  end

  // Saturating count of cycles lost to either stall source.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if ((mem_stall || load_use) && (stall_cnt_o != CNT_MAX)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vectors, a behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_pipeline_stall_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int W           = 8 + CNT_W;
  localparam int CNT_SAT     = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             ID_EX_MemRead_i;
  logic [4:0]       ID_EX_Rt_i;
  logic [4:0]       IF_ID_Rs_i;
  logic [4:0]       IF_ID_Rt_i;
  logic             Branch_taken_i;
  logic             EX_MEM_MemRead_i;
  logic             EX_MEM_MemWrite_i;
  logic             mem_ack_i;
  logic             PCWrite_o;
  logic             IF_IDWrite_o;
  logic             ID_EX_Bubble_o;
  logic             IF_ID_Flush_o;
  logic             Pipe_Stall_o;
  logic             mem_req_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  // Model state, in plain terms: stalled cycles so far, length of the
  // current run of memory-stall cycles, whether the last cycle waited on
  // memory, and whether any run reached the timeout.
  int   m_cnt  = 0;
  int   m_run  = 0;
  logic m_prev = 1'b0;
  logic m_err  = 1'b0;

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ID_EX_MemRead_i   (ID_EX_MemRead_i),
    .ID_EX_Rt_i        (ID_EX_Rt_i),
    .IF_ID_Rs_i        (IF_ID_Rs_i),
    .IF_ID_Rt_i        (IF_ID_Rt_i),
    .Branch_taken_i    (Branch_taken_i),
    .EX_MEM_MemRead_i  (EX_MEM_MemRead_i),
    .EX_MEM_MemWrite_i (EX_MEM_MemWrite_i),
    .mem_ack_i         (mem_ack_i),
    .PCWrite_o         (PCWrite_o),
    .IF_IDWrite_o      (IF_IDWrite_o),
    .ID_EX_Bubble_o    (ID_EX_Bubble_o),
    .IF_ID_Flush_o     (IF_ID_Flush_o),
    .Pipe_Stall_o      (Pipe_Stall_o),
    .mem_req_o         (mem_req_o),
    .mem_err_o         (mem_err_o),
    .stall_cnt_o       (stall_cnt_o),
    .dbg_state         (dbg_state)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  task automatic record(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_load_use();
    return ID_EX_MemRead_i && (ID_EX_Rt_i != 5'd0) &&
           ((ID_EX_Rt_i == IF_ID_Rs_i) || (ID_EX_Rt_i == IF_ID_Rt_i));
  endfunction

  function automatic logic model_mem_stall();
    return (EX_MEM_MemRead_i || EX_MEM_MemWrite_i) && !mem_ack_i;
  endfunction

  // Expected output vector for the current inputs and model history.
  function automatic logic [W-1:0] model_out();
    logic pcw, ifw, bub, fl, ps, req;
    if (rst_i) return {2'b11, 6'b000000, CNT_W'(0)};
    pcw = 1'b1; ifw = 1'b1; bub = 1'b0; fl = 1'b0; ps = 1'b0;
    req = EX_MEM_MemRead_i || EX_MEM_MemWrite_i;
    if (model_mem_stall()) begin
      pcw = 1'b0; ifw = 1'b0; ps = 1'b1;
    end else if (model_load_use()) begin
      pcw = 1'b0; ifw = 1'b0; bub = 1'b1;
    end else if (Branch_taken_i) begin
      fl = 1'b1;
    end
    return {pcw, ifw, bub, fl, ps, req, m_err, m_prev, CNT_W'(m_cnt)};
  endfunction

  // Model history advance at each clock edge; reset clears it at once.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_cnt = 0; m_run = 0; m_prev = 1'b0; m_err = 1'b0;
    end else begin
      if (model_mem_stall() || model_load_use())
        m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
      if (model_mem_stall()) m_run = m_run + 1;
      else m_run = 0;
      if (m_run >= MEM_TIMEOUT) m_err = 1'b1;
      m_prev = model_mem_stall();
    end
  end

  // Scoreboard: every falling edge the model's expectation is queued and
  // compared against the DUT outputs.
  always @(negedge clk_i) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    exp_q.push_back(model_out());
    got = {PCWrite_o, IF_IDWrite_o, ID_EX_Bubble_o, IF_ID_Flush_o, Pipe_Stall_o,
           mem_req_o, mem_err_o, dbg_state, stall_cnt_o};
    exp = exp_q.pop_front();
    record("cycle_model", 32'(got), 32'(exp));
  end

  // Driver: set inputs just after an edge, then settle before literal checks.
  task automatic apply(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic emr,
                       input logic emw, input logic ack);
    ID_EX_MemRead_i   = mr;
    ID_EX_Rt_i        = ert;
    IF_ID_Rs_i        = rs;
    IF_ID_Rt_i        = rt;
    Branch_taken_i    = br;
    EX_MEM_MemRead_i  = emr;
    EX_MEM_MemWrite_i = emw;
    mem_ack_i         = ack;
    #2;
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    tick();
    // Reset idle values.
    record("rst_pcwrite", 32'(PCWrite_o), 32'd1);
    record("rst_ifidwrite", 32'(IF_IDWrite_o), 32'd1);
    record("rst_stall", 32'(Pipe_Stall_o), 32'd0);
    record("rst_cnt", 32'(stall_cnt_o), 32'd0);
    record("rst_err", 32'(mem_err_o), 32'd0);
    record("rst_state", 32'(dbg_state), 32'd0);
    tick();
    rst_i = 1'b0;

    // Load-use on rs: one-cycle bubble.
    apply(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    record("lu_pcwrite", 32'(PCWrite_o), 32'd0);
    record("lu_ifidwrite", 32'(IF_IDWrite_o), 32'd0);
    record("lu_bubble", 32'(ID_EX_Bubble_o), 32'd1);
    record("lu_nostall", 32'(Pipe_Stall_o), 32'd0);
    tick();
    idle();
    record("lu_bubble_gone", 32'(ID_EX_Bubble_o), 32'd0);
    record("lu_cnt", 32'(stall_cnt_o), 32'd1);
    tick();

    // $0 destination: no hazard.
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    record("r0_bubble", 32'(ID_EX_Bubble_o), 32'd0);
    record("r0_pcwrite", 32'(PCWrite_o), 32'd1);
    tick();
    // Match on rt.
    apply(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    record("lu_rt_bubble", 32'(ID_EX_Bubble_o), 32'd1);
    tick();
    // No match.
    apply(1'b1, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    record("nomatch_bubble", 32'(ID_EX_Bubble_o), 32'd0);
    record("cnt_after_rt", 32'(stall_cnt_o), 32'd2);
    tick();

    // Branch alone flushes.
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    record("br_flush", 32'(IF_ID_Flush_o), 32'd1);
    record("br_pcwrite", 32'(PCWrite_o), 32'd1);
    tick();
    // Load-use suppresses the flush.
    apply(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    record("lu_br_flush", 32'(IF_ID_Flush_o), 32'd0);
    record("lu_br_bubble", 32'(ID_EX_Bubble_o), 32'd1);
    tick();

    // Memory wait: three stall cycles, then ack.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      record("mw_stall", 32'(Pipe_Stall_o), 32'd1);
      record("mw_req", 32'(mem_req_o), 32'd1);
      record("mw_bubble", 32'(ID_EX_Bubble_o), 32'd0);
      record("mw_state", 32'(dbg_state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    record("mw_ack_stall", 32'(Pipe_Stall_o), 32'd0);
    record("mw_ack_req", 32'(mem_req_o), 32'd1);
    record("mw_ack_pcwrite", 32'(PCWrite_o), 32'd1);
    tick();
    idle();
    record("mw_state_run", 32'(dbg_state), 32'd0);
    record("mw_cnt", 32'(stall_cnt_o), 32'd6);
    tick();

    // Zero-wait store.
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    record("zw_stall", 32'(Pipe_Stall_o), 32'd0);
    record("zw_req", 32'(mem_req_o), 32'd1);
    tick();
    idle();
    record("zw_state", 32'(dbg_state), 32'd0);
    record("zw_cnt", 32'(stall_cnt_o), 32'd6);
    tick();

    // Memory wait + load-use + branch, then ack.
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      record("co_stall", 32'(Pipe_Stall_o), 32'd1);
      record("co_bubble", 32'(ID_EX_Bubble_o), 32'd0);
      record("co_flush", 32'(IF_ID_Flush_o), 32'd0);
      tick();
    end
    apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    record("co_ack_stall", 32'(Pipe_Stall_o), 32'd0);
    record("co_ack_bubble", 32'(ID_EX_Bubble_o), 32'd1);
    record("co_ack_flush", 32'(IF_ID_Flush_o), 32'd0);
    tick();
    idle();
    record("co_cnt", 32'(stall_cnt_o), 32'd9);
    tick();

    // Request dropped without ack: back to RUN after one idle cycle.
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
    record("drop_state_wait", 32'(dbg_state), 32'd1);
    tick();
    idle();
    record("drop_state_run", 32'(dbg_state), 32'd0);
    record("drop_cnt", 32'(stall_cnt_o), 32'd11);
    tick();

    // Timeout: error shows on the fourth MEM_WAIT cycle (fifth stall cycle).
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      record("to_err", 32'(mem_err_o), (i == 4) ? 32'd1 : 32'd0);
      record("to_stall", 32'(Pipe_Stall_o), 32'd1);
      tick();
    end
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    record("to_err_ack", 32'(mem_err_o), 32'd1);
    record("to_cnt_sat", 32'(stall_cnt_o), 32'(CNT_SAT));
    tick();
    // Saturated counter holds under further stalls.
    apply(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    record("sat_hold", 32'(stall_cnt_o), 32'(CNT_SAT));
    record("to_err_sticky", 32'(mem_err_o), 32'd1);
    tick();

    // Asynchronous reset in the middle of a memory wait.
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    record("ar_pre_state", 32'(dbg_state), 32'd1);
    rst_i = 1'b1;
    #1;
    record("ar_pcwrite", 32'(PCWrite_o), 32'd1);
    record("ar_stall", 32'(Pipe_Stall_o), 32'd0);
    record("ar_req", 32'(mem_req_o), 32'd0);
    record("ar_flush", 32'(IF_ID_Flush_o), 32'd0);
    record("ar_err", 32'(mem_err_o), 32'd0);
    record("ar_cnt", 32'(stall_cnt_o), 32'd0);
    record("ar_state", 32'(dbg_state), 32'd0);
    tick();
    rst_i = 1'b0;
    idle();
    record("ar_post_state", 32'(dbg_state), 32'd0);
    record("ar_post_cnt", 32'(stall_cnt_o), 32'd0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
